// File: rtl/win_counter.sv
// Per-player round-win counter with edge-detected wins, a timed playfield reset request and a game-over latch.
// Optional seven-segment decode of count is built only when WIN_COUNTER_HEX_EN is defined.
module win_counter #(
    parameter int MAX_WINS    = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win_in,
    input  logic       other_done,
    output logic       round_reset,
    output logic [2:0] count,
    output logic       game_over,
    output logic [6:0] hex
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        DONE
    } state_t;

    localparam logic [2:0] LAST_WIN  = 3'(MAX_WINS - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] timer;
    logic       win_prev;
    logic       win_event;

    // win_prev resets high so a win_in already high at reset release is not a rising edge
    assign win_event = win_in && !win_prev && !other_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= 3'd0;
            timer       <= 4'd0;
            win_prev    <= 1'b1;
            round_reset <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            win_prev <= win_in;
            case (state)
                IDLE: begin
                    if (win_event) begin
                        count       <= count + 3'd1;
                        round_reset <= 1'b1;
                        if (count == LAST_WIN) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                        end else begin
                            timer <= HOLD_LOAD;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (timer == 4'd0) begin
                        state       <= RELEASE;
                        round_reset <= 1'b0;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                RELEASE: begin
                    if (!win_in) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state       <= DONE;
                    round_reset <= 1'b1;
                    game_over   <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    round_reset <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

`ifdef WIN_COUNTER_HEX_EN
    always_comb begin
        hex = 7'b1111111;
        case (count)
            3'd0: hex = 7'b1000000;
            3'd1: hex = 7'b1111001;
            3'd2: hex = 7'b0100100;
            3'd3: hex = 7'b0110000;
            3'd4: hex = 7'b0011001;
            3'd5: hex = 7'b0010010;
            3'd6: hex = 7'b0000010;
            3'd7: hex = 7'b1111000;
            default: hex = 7'b1111111;
        endcase
    end
`else
    assign hex = 7'b1111111;
`endif

endmodule

// File: tb/tb_win_counter.sv
// Directed bench for win_counter: vector table from reset, then hand sequences for
// held wins, other_done suppression, game over and asynchronous reset.
module tb_win_counter;

    logic       clk;
    logic       reset;
    logic       win_in;
    logic       other_done;
    logic       round_reset;
    logic [2:0] count;
    logic       game_over;
    logic [6:0] hex;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic       win;
        logic       od;
        logic [2:0] exp_count;
        logic       exp_rr;
        logic       exp_go;
    } vec_t;

    vec_t vecs[15];

    win_counter #(.MAX_WINS(7), .HOLD_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .win_in(win_in),
        .other_done(other_done),
        .round_reset(round_reset),
        .count(count),
        .game_over(game_over),
        .hex(hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_expected(input logic [2:0] c);
`ifdef WIN_COUNTER_HEX_EN
        case (c)
            3'd0: return 7'b1000000;
            3'd1: return 7'b1111001;
            3'd2: return 7'b0100100;
            3'd3: return 7'b0110000;
            3'd4: return 7'b0011001;
            3'd5: return 7'b0010010;
            3'd6: return 7'b0000010;
            default: return 7'b1111000;
        endcase
`else
        return 7'b1111111;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_output(input string name, input logic [2:0] exp_count,
                                input logic exp_rr, input logic exp_go);
        compare({name, ".count"}, int'(count), int'(exp_count));
        compare({name, ".round_reset"}, int'(round_reset), int'(exp_rr));
        compare({name, ".game_over"}, int'(game_over), int'(exp_go));
        compare({name, ".hex"}, int'(hex), int'(hex_expected(exp_count)));
    endtask

    task automatic apply_stimulus(input logic win, input logic od);
        win_in     = win;
        other_done = od;
        tick();
    endtask

    // One-cycle win pulse, checked right after the sampling edge, then idle long enough to return to IDLE
    task automatic pulse_win(input string name, input logic [2:0] exp_count,
                             input logic exp_rr, input logic exp_go);
        apply_stimulus(1'b1, other_done);
        check_output(name, exp_count, exp_rr, exp_go);
        win_in = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b0;
        win_in       = 1'b0;
        other_done   = 1'b0;

        //          win   od    cnt   rr    go
        vecs[0]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0};

        #12;
        check_output("reset", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_output("post_reset", 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].win, vecs[i].od);
            check_output($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_rr, vecs[i].exp_go);
        end

        // Asynchronous reset two cycles into REQ, observed between edges
        apply_stimulus(1'b1, 1'b0);
        check_output("async.enter_req", 3'd3, 1'b1, 1'b0);
        win_in = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_output("async.reset_mid_req", 3'd0, 1'b0, 1'b0);

        // win_in high through reset release must not count
        win_in = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        check_output("held_through_reset", 3'd0, 1'b0, 1'b0);

        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        check_output("hold20.first", 3'd1, 1'b1, 1'b0);
        repeat (19) tick();
        check_output("hold20.end", 3'd1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_output("hold20.low", 3'd1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        check_output("hold20.rise_again", 3'd2, 1'b1, 1'b0);
        win_in = 1'b0;
        repeat (6) tick();

        pulse_win("pulse3", 3'd3, 1'b1, 1'b0);

        other_done = 1'b1;
        pulse_win("od_suppress", 3'd3, 1'b0, 1'b0);
        check_output("od_suppress.after", 3'd3, 1'b0, 1'b0);
        other_done = 1'b0;
        tick();

        // other_done rising during REQ must not abort the hold
        apply_stimulus(1'b1, 1'b0);
        check_output("od_in_req.start", 3'd4, 1'b1, 1'b0);
        win_in     = 1'b0;
        other_done = 1'b1;
        tick();
        check_output("od_in_req.hold", 3'd4, 1'b1, 1'b0);
        repeat (5) tick();
        check_output("od_in_req.done", 3'd4, 1'b0, 1'b0);
        other_done = 1'b0;
        tick();

        pulse_win("pulse5", 3'd5, 1'b1, 1'b0);
        pulse_win("pulse6", 3'd6, 1'b1, 1'b0);
        pulse_win("pulse7", 3'd7, 1'b1, 1'b1);
        check_output("done.stuck", 3'd7, 1'b1, 1'b1);
        other_done = 1'b1;
        repeat (3) tick();
        other_done = 1'b0;
        pulse_win("pulse8", 3'd7, 1'b1, 1'b1);
        check_output("done.after8", 3'd7, 1'b1, 1'b1);

        #3;
        reset = 1'b0;
        #1;
        check_output("async.reset_in_done", 3'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
